ram_rmw_ctrl: RTL and testbench
===============================

Name: ram_rmw_ctrl

Overview:
Request-side controller directly upstream of the single-port 1-cycle-latency RAM block. It accepts byte-addressed load/store requests on a valid/ready interface and converts them into word-addressed RAM accesses. Partial stores (byte enables) become read-modify-write sequences. It returns one response per request on a valid/ready interface, with at most one request in flight.

Parameters:
DEPTH, 1024, RAM word count; must match the RAM instance.
WIDTH, 32, data width in bits; multiple of 8.
ADDR_W, 32, request byte-address width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  WIDTH  store data
req_be  in  WIDTH/8  store byte enables; ignored for loads
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts the response
resp_rdata  out  WIDTH  load data; 0 for stores
resp_err  out  1  request error; see Optional Feature
ram_we  out  1  RAM write enable
ram_addr  out  $clog2(DEPTH)  RAM word address
ram_wdata  out  WIDTH  RAM write data
ram_rdata  in  WIDTH  RAM read data, valid the cycle after the address is presented

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, so req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - ram_we=0, ram_addr=0, ram_wdata=0.
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP. All RAM-side outputs are registered.
- req_ready=1 only in IDLE. A request is accepted when req_valid and req_ready are both 1. On acceptance the controller latches write, word index, wdata and be.
- Word index: req_addr[$clog2(WIDTH/8) +: $clog2(DEPTH)]. Low $clog2(WIDTH/8) address bits are ignored unless the feature is enabled.
- Transitions from IDLE:
  - Load -> RD_ADDR.
  - Store with be all-ones -> WR.
  - Store with be = 0 -> RESP. No RAM access.
  - Other store (partial) -> RD_ADDR.
- RD_ADDR: drives ram_addr with ram_we=0 for one cycle -> RD_DATA.
- RD_DATA: samples ram_rdata.
  - Load: resp_rdata <= ram_rdata -> RESP.
  - Partial store: merge byte-wise, byte i = be[i] ? wdata byte i : rdata byte i. Latch the merged word into ram_wdata -> WR.
- WR: ram_we=1 for exactly one cycle, with ram_addr and ram_wdata stable -> RESP. ram_we is 0 in every other state.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready=1. On that handshake -> IDLE.
- Back-to-back requests: after the response handshake, the next request can be accepted the following cycle.
- Latency, from the acceptance edge to resp_valid high:
  - Full store: 2 cycles.
  - Load: 3 cycles.
  - Partial store: 4 cycles.
  - be=0 store: 1 cycle.
- Reset mid-operation: state returns to IDLE and ram_we drops immediately (asynchronously). A pending partial store is discarded and RAM is never written. Any pending response is dropped.
- Addresses beyond DEPTH words wrap modulo DEPTH unless the feature is enabled.

Optional Feature:
Macro RAM_CTRL_RANGE_CHK_EN.
- Defined: a request is rejected if its address is misaligned (nonzero low byte-offset bits) or req_addr >= DEPTH*WIDTH/8. A rejected request goes IDLE -> RESP with resp_err=1 and resp_rdata=0. There is no RAM read and ram_we is never asserted.
- Undefined: resp_err is tied to 0, offset bits are ignored, and upper address bits are truncated (wrap).

Test Plan:
1. Full store 0x10, data 0xDEADBEEF, be=4'hF -> ram_we high exactly one cycle at ram_addr=4, resp_valid 2 cycles after acceptance. Load 0x10 -> resp_rdata=0xDEADBEEF, 3 cycles after acceptance.
2. After (1), partial store 0x10, data 0x11223344, be=4'b0101 -> one RAM read then one write. resp_valid 4 cycles after acceptance. Load 0x10 -> 0xDE22BE44.
3. Load with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, a concurrent req_valid is not accepted. Release -> IDLE, req_ready=1 the next cycle.
4. Partial store in flight, rst_n pulsed low during RD_DATA -> ram_we never asserted. After reset, load 0x10 still returns 0xDEADBEEF, and all outputs show reset values during reset.
5. Store be=4'h0 -> no ram_we, resp_valid after 1 cycle, resp_rdata=0.
6. Load 0xFFC (word 1023) works normally, while address 0x1000 or 0x13 behaves as follows:
   - With RAM_CTRL_RANGE_CHK_EN: resp_err=1, no RAM access.
   - Without the macro: 0x1000 aliases word 0, 0x13 accesses word 4, resp_err=0.

Source files
------------

// File: rtl/ram_rmw_ctrl.sv
// ram_rmw_ctrl: byte-addressed load/store front end for a single-port, 1-cycle-latency RAM.
// Partial stores run as read-modify-write. Define RAM_CTRL_RANGE_CHK_EN to reject bad addresses.
module ram_rmw_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  input  logic [WIDTH/8-1:0]       req_be,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_rdata,
  output logic                     resp_err,
  output logic                     ram_we,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [WIDTH-1:0]         ram_wdata,
  input  logic [WIDTH-1:0]         ram_rdata
);
  localparam int BW  = WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_e;

  state_e            state_q, state_d;
  logic              write_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [BW-1:0]     be_q;
  logic [WIDTH-1:0]  resp_rdata_q;
  logic              resp_err_q;
  logic              ram_we_q;
  logic [AW-1:0]     ram_addr_q;
  logic [WIDTH-1:0]  ram_wdata_q;
  logic [WIDTH-1:0]  merged;
  logic [AW-1:0]     req_idx;
  logic              req_bad;

  assign req_idx = req_addr[OFF +: AW];

`ifdef RAM_CTRL_RANGE_CHK_EN
  localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(DEPTH * BW);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BW - 1);
  assign req_bad = ((req_addr & OFF_MASK) != '0) || ({1'b0, req_addr} >= LIMIT);
`else
  // Offset and upper address bits are deliberately dropped: addresses wrap.
  logic unused_addr;
  assign unused_addr = ^req_addr;
  assign req_bad     = 1'b0;
`endif

  always_comb begin
    merged = '0;
    for (int i = 0; i < BW; i++) begin
      merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : ram_rdata[8*i +: 8];
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)          state_d = RESP;
          else if (!req_write)  state_d = RD_ADDR;
          else if (&req_be)     state_d = WR;
          else if (~|req_be)    state_d = RESP;
          else                  state_d = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q      <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      // Registered copy of the WR state decode keeps the strobe glitch-free.
      ram_we_q <= (state_d == WR);
      if (state_q == IDLE && req_valid) begin
        write_q      <= req_write;
        wdata_q      <= req_wdata;
        be_q         <= req_be;
        resp_rdata_q <= '0;
        resp_err_q   <= req_bad;
        if (state_d == RD_ADDR || state_d == WR) ram_addr_q  <= req_idx;
        if (state_d == WR)                       ram_wdata_q <= req_wdata;
      end
      if (state_q == RD_DATA) begin
        if (write_q) ram_wdata_q  <= merged;
        else         resp_rdata_q <= ram_rdata;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// tb_ram_rmw_ctrl: scoreboarded random and directed test of ram_rmw_ctrl against a word-array model.
// Expectations follow RAM_CTRL_RANGE_CHK_EN when it is defined.
module tb_ram_rmw_ctrl;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  ram_rmw_ctrl #(.DEPTH(DEPTH), .WIDTH(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    int          waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [DEPTH];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: apply the request to the word array and predict the response.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output exp_t e);
    int          word;
    logic        bad;
    logic [31:0] nw;
    word = int'((a >> 2) % DEPTH);
`ifdef RAM_CTRL_RANGE_CHK_EN
    bad = (a % 4 != 0) || (a >= DEPTH * 4);
`else
    bad = 1'b0;
`endif
    e.err = bad; e.rdata = 32'h0; e.writes = 0; e.waddr = word; e.wdata = 32'h0;
    if (bad)            e.lat = 1;
    else if (!w)        e.lat = 3;
    else if (be == 4'h0) e.lat = 1;
    else if (be == 4'hF) e.lat = 2;
    else                e.lat = 4;
    if (!bad && !w) e.rdata = ref_mem[word];
    if (!bad && w && be != 4'h0) begin
      nw = ref_mem[word];
      for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = d[8*i +: 8];
      ref_mem[word] = nw;
      e.writes = 1;
      e.wdata  = nw;
    end
  endtask

  // Starts and ends at posedge+1 with the controller idle.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int stall);
    exp_t e;
    int   n;
    model(w, a, d, be, e);
    sb.push_back(e);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("resp_timeout", resp_valid, 32'(n), 32'd20);
    for (int i = 0; i < stall; i++) begin
      check("ready_during_resp", !req_ready, {31'b0, req_ready}, 32'd0);
      check("valid_held", resp_valid, {31'b0, resp_valid}, 32'd1);
      req_valid = 1'b1; req_write = 1'($urandom); req_addr = $urandom; req_be = 4'($urandom);
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("ready_after_resp", req_ready, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", req_ready == 1'b1, {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", resp_valid == 1'b0, {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata == 32'h0, resp_rdata, 32'h0);
    check("rst_resp_err", resp_err == 1'b0, {31'b0, resp_err}, 32'd0);
    check("rst_ram_we", ram_we == 1'b0, {31'b0, ram_we}, 32'd0);
    check("rst_ram_addr", ram_addr == 10'h0, {22'b0, ram_addr}, 32'h0);
    check("rst_ram_wdata", ram_wdata == 32'h0, ram_wdata, 32'h0);
  endtask

  // Monitor: tracks acceptance, RAM writes and response timing, then scores each handshake.
  int          acc_cyc, wr_cnt, lat, last_waddr;
  logic [31:0] last_wdata, hold_rdata;
  logic        hold_err, seen_valid;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen_valid = 1'b0;
      wr_cnt     = 0;
    end else begin
      if (req_valid && req_ready) begin acc_cyc = cyc; wr_cnt = 0; seen_valid = 1'b0; end
      if (ram_we) begin wr_cnt++; last_waddr = int'(ram_addr); last_wdata = ram_wdata; end
      if (resp_valid && !seen_valid) begin
        seen_valid = 1'b1; lat = cyc - acc_cyc; hold_rdata = resp_rdata; hold_err = resp_err;
      end else if (resp_valid) begin
        check("rdata_stable", resp_rdata == hold_rdata, resp_rdata, hold_rdata);
        check("err_stable", resp_err == hold_err, {31'b0, resp_err}, {31'b0, hold_err});
      end
      if (resp_valid && resp_ready) begin
        seen_valid = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_resp", 1'b0, resp_rdata, 32'h0);
        end else begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata == e.rdata, resp_rdata, e.rdata);
          check("resp_err", resp_err == e.err, {31'b0, resp_err}, {31'b0, e.err});
          check("latency", lat == e.lat, 32'(lat), 32'(e.lat));
          check("ram_writes", wr_cnt == e.writes, 32'(wr_cnt), 32'(e.writes));
          if (e.writes == 1 && wr_cnt == 1) begin
            check("ram_waddr", last_waddr == e.waddr, 32'(last_waddr), 32'(e.waddr));
            check("ram_wdata", last_wdata == e.wdata, last_wdata, e.wdata);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;
    #12;
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full store then load, partial store then load.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 0);
    issue(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 0);
    check("rmw_result_model", ref_mem[4] == 32'hDE22BE44, ref_mem[4], 32'hDE22BE44);

    // Stalled response with a competing request.
    issue(1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Reset during RD_DATA of a partial store: the RAM must stay untouched.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_be = 4'b0011;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    check("rst_ram_we_held", ram_we == 1'b0, {31'b0, ram_we}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ram_we", ram_we == 1'b0, {31'b0, ram_we}, 32'd0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 0);

    // be=0 store, top word, out-of-range and misaligned addresses.
    issue(1'b1, 32'h20, 32'h55AA55AA, 4'h0, 0);
    issue(1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 0);
    issue(1'b0, 32'hFFC, 32'h0, 4'h0, 0);
    issue(1'b0, 32'h1000, 32'h0, 4'h0, 0);
    issue(1'b0, 32'h13, 32'h0, 4'h0, 0);
    issue(1'b1, 32'h1000, 32'h12345678, 4'hF, 1);
    issue(1'b0, 32'h0, 32'h0, 4'h0, 0);

    // Random traffic, mostly in range, occasionally anywhere in the address space.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = $urandom_range(0, DEPTH * 4 - 1) & 32'hFFFF_FFFC;
      issue(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size() == 0, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
